// File: rtl/datapath_sequencer_pkg.sv
// Shared constants for the datapath sequencer: control-word layout, opcodes, shift codes, FSM states.
// A captured command is carried around as one packed cmd_t.
package seq_pkg;
    localparam int CTRL_W = 9;
    localparam int CNT_W  = 4;

    localparam logic [CTRL_W-1:0] IDLE_WORD  = 9'h000;
    localparam logic [CTRL_W-1:0] CLEAR_WORD = 9'h0C0;

    // [8] reserved, [7] Q clear, [6] R clear, [5:4] shift, [3] mux, [2:0] ALU op
    localparam int BIT_QCLR     = 7;
    localparam int BIT_RCLR     = 6;
    localparam int BIT_SHIFT_LO = 4;
    localparam int BIT_MUX      = 3;
    localparam int BIT_OP_LO    = 0;

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;

    localparam logic [1:0] SH_NONE  = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;
    localparam logic [1:0] SH_ROT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]       op;
        logic             src;
        logic [1:0]       shift;
        logic             clr;
        logic [CNT_W-1:0] count;
    } cmd_t;
endpackage

// File: rtl/datapath_sequencer_if.sv
// Command handshake plus datapath control outputs of the sequencer.
// master = instruction source side, slave = the sequencer itself.
interface datapath_sequencer_if;
    import seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_src;
    logic [1:0]        cmd_shift;
    logic              cmd_clr;
    logic [CNT_W-1:0]  cmd_count;
    logic [CTRL_W-1:0] ctrl_bus;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_shift, cmd_clr, cmd_count,
        input  cmd_ready, ctrl_bus, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_shift, cmd_clr, cmd_count,
        output cmd_ready, ctrl_bus, busy, done
    );
endinterface

// File: rtl/datapath_sequencer_ctrl_word_encoder.sv
// Combinational map from sequencer state and captured command fields to the 9-bit control word.
module ctrl_word_encoder
    import seq_pkg::*;
(
    input  state_e            state_i,
    input  logic [2:0]        op_i,
    input  logic              src_i,
    input  logic [1:0]        shift_i,
    output logic [CTRL_W-1:0] word_o
);
    always_comb begin
        word_o = IDLE_WORD;
        case (state_i)
            S_CLEAR: word_o = CLEAR_WORD;
            S_EXEC: begin
                word_o                     = '0;
                word_o[BIT_OP_LO +: 3]     = op_i;
                word_o[BIT_MUX]            = src_i;
                word_o[BIT_SHIFT_LO +: 2]  = shift_i;
            end
            S_IDLE, S_DONE: word_o = IDLE_WORD;
            default: word_o = IDLE_WORD;
        endcase
    end
endmodule

// File: rtl/datapath_sequencer.sv
// Expands one command into an optional clear cycle plus count+1 execute cycles, then a done pulse.
// Registered outputs; `SEQ_CMD_QUEUE_EN adds a one-entry buffer so commands can be accepted while busy.
module datapath_sequencer
    import seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              src_q, src_d;
    logic [1:0]        shift_q, shift_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              done_q, done_d;
    cmd_t              in_cmd, start_cmd;
    logic              xfer, start;

`ifdef SEQ_CMD_QUEUE_EN
    cmd_t              buf_q, buf_d;
    logic              buf_full_q, buf_full_d;

    assign bus.cmd_ready = !buf_full_q;
`else
    assign bus.cmd_ready = (state_q == S_IDLE);
`endif

    assign in_cmd = '{op: bus.cmd_op, src: bus.cmd_src, shift: bus.cmd_shift,
                      clr: bus.cmd_clr, count: bus.cmd_count};
    assign xfer   = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        src_d     = src_q;
        shift_d   = shift_q;
        start     = 1'b0;
        start_cmd = in_cmd;
`ifdef SEQ_CMD_QUEUE_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif
        case (state_q)
            S_IDLE:  start = xfer;
            S_CLEAR: state_d = S_EXEC;
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SEQ_CMD_QUEUE_EN
                // Chain straight into the next command so no IDLE bubble appears.
                if (buf_full_q) begin
                    start      = 1'b1;
                    start_cmd  = buf_q;
                    buf_full_d = 1'b0;
                end else begin
                    start = xfer;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SEQ_CMD_QUEUE_EN
        if (xfer && (state_q == S_CLEAR || state_q == S_EXEC)) begin
            buf_d      = in_cmd;
            buf_full_d = 1'b1;
        end
`endif
        if (start) begin
            state_d = start_cmd.clr ? S_CLEAR : S_EXEC;
            cnt_d   = start_cmd.count;
            op_d    = start_cmd.op;
            src_d   = start_cmd.src;
            shift_d = start_cmd.shift;
        end
    end

    assign done_d = (state_d == S_DONE);

    ctrl_word_encoder u_enc (
        .state_i (state_d),
        .op_i    (op_d),
        .src_i   (src_d),
        .shift_i (shift_d),
        .word_o  (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_PASS_A;
            src_q      <= 1'b0;
            shift_q    <= SH_NONE;
            ctrl_q     <= IDLE_WORD;
            done_q     <= 1'b0;
`ifdef SEQ_CMD_QUEUE_EN
            buf_q      <= '0;
            buf_full_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            src_q      <= src_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
`ifdef SEQ_CMD_QUEUE_EN
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
`endif
        end
    end

    assign bus.ctrl_bus = ctrl_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: driver pushes per-command expectations, negedge monitor checks.
// A small behavioural ALU/R/Q model lets directed commands check the Q result at done.
module tb_datapath_sequencer;
    import seq_pkg::*;

`ifdef SEQ_CMD_QUEUE_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [8:0] exec_word;
        logic       clr;
        int         n_exec;
        bit         chk_q;
        logic [7:0] q_exp;
    } exp_t;

    logic clk;
    logic reset;
    datapath_sequencer_if bus ();

    datapath_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [8:0] trace[$];
    int         outstanding = 0;
    bit         lat_pend = 0;
    logic [8:0] lat_word = '0;
    exp_t       mon_e;

    logic [7:0] dp_a = 8'd0;
    logic [7:0] dp_b = 8'd0;
    logic [7:0] dp_r;
    logic [7:0] dp_q;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] dp_alu(input logic [8:0] w, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] r);
        logic [7:0] m;
        m = w[3] ? r : b;
        return (w[2:0] == OP_ADD) ? 8'(a + m) : a;
    endfunction

    // Behavioural datapath: clears win, otherwise R and Q both load the ALU result.
    always @(posedge clk) begin
        if (bus.ctrl_bus[BIT_QCLR] || bus.ctrl_bus[BIT_RCLR]) begin
            if (bus.ctrl_bus[BIT_QCLR]) dp_q <= 8'd0;
            if (bus.ctrl_bus[BIT_RCLR]) dp_r <= 8'd0;
        end else begin
            dp_r <= dp_alu(bus.ctrl_bus, dp_a, dp_b, dp_r);
            dp_q <= dp_alu(bus.ctrl_bus, dp_a, dp_b, dp_r);
        end
    end

    function automatic bit trace_ok(input exp_t e);
        int n;
        int first;
        first = e.clr ? 1 : 0;
        n = e.n_exec + first;
        if (trace.size() != n) return 1'b0;
        if (e.clr && trace[0] != 9'h0C0) return 1'b0;
        for (int i = first; i < n; i++) begin
            if (trace[i] != e.exec_word) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check(bus.busy == (outstanding > 0), "busy", int'(bus.busy), int'(outstanding > 0));
            check(bus.cmd_ready == (outstanding < CAP), "cmd_ready", int'(bus.cmd_ready),
                  int'(outstanding < CAP));
            if (lat_pend) begin
                check(bus.ctrl_bus == lat_word, "first_word", int'(bus.ctrl_bus), int'(lat_word));
                lat_pend = 1'b0;
            end
            if (bus.done) begin
                check(sb.size() > 0, "done_expected", sb.size(), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check(trace_ok(mon_e), "trace", trace.size(),
                          mon_e.n_exec + (mon_e.clr ? 1 : 0));
                    check(bus.ctrl_bus == 9'h000, "done_word", int'(bus.ctrl_bus), 0);
                    if (mon_e.chk_q) check(dp_q == mon_e.q_exp, "q_result", int'(dp_q), int'(mon_e.q_exp));
                    outstanding--;
                end
                trace.delete();
            end else if (bus.busy) begin
                trace.push_back(bus.ctrl_bus);
            end else begin
                check(bus.ctrl_bus == 9'h000, "idle_word", int'(bus.ctrl_bus), 0);
            end
        end else begin
            trace.delete();
            lat_pend = 1'b0;
        end
    end

    task automatic garbage();
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_src   = 1'($urandom_range(0, 1));
        bus.cmd_shift = 2'($urandom_range(0, 3));
        bus.cmd_clr   = 1'($urandom_range(0, 1));
        bus.cmd_count = 4'($urandom_range(0, 15));
    endtask

    // Called at posedge+1; holds cmd_valid until accepted, returns at posedge+1 after the transfer edge.
    task automatic send(input bit jitter, input logic [2:0] op, input logic src,
                        input logic [1:0] sh, input logic clr, input logic [CNT_W-1:0] cnt,
                        input bit chk_q, input logic [7:0] q_exp);
        bit   acc;
        bit   was_idle;
        int   waited;
        exp_t e;
        acc = 1'b0;
        waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_shift = sh;
        bus.cmd_clr   = clr;
        bus.cmd_count = cnt;
        while (!acc && waited < 200) begin
            #2;
            acc = bus.cmd_ready;
            was_idle = !bus.busy;
            @(posedge clk);
            #1;
            if (acc) begin
                e.exec_word = {3'b000, bus.cmd_shift, bus.cmd_src, bus.cmd_op};
                e.clr       = bus.cmd_clr;
                e.n_exec    = int'(bus.cmd_count) + 1;
                e.chk_q     = chk_q;
                e.q_exp     = q_exp;
                sb.push_back(e);
                outstanding++;
                if (was_idle) begin
                    lat_word = bus.cmd_clr ? 9'h0C0 : e.exec_word;
                    lat_pend = 1'b1;
                end
            end else begin
                waited++;
                if (jitter) garbage();
            end
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=accepted", waited);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (outstanding != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (outstanding != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", outstanding);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        garbage();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Single ADD, count=0: 8+5
        dp_a = 8'd8;
        dp_b = 8'd5;
        send(1'b0, OP_ADD, 1'b0, SH_NONE, 1'b0, 4'd0, 1'b1, 8'd13);
        wait_idle();

        // Accumulate with clear, count=2: Q ends at 3*A
        dp_a = 8'd3;
        send(1'b0, OP_ADD, 1'b1, SH_NONE, 1'b1, 4'd2, 1'b1, 8'd9);
        wait_idle();

        // Back-to-back pair: held off without the buffer, chained with it
        send(1'b0, OP_ADD, 1'b0, SH_NONE, 1'b0, 4'd3, 1'b0, 8'd0);
        send(1'b0, OP_PASS_A, 1'b1, SH_LEFT, 1'b1, 4'd1, 1'b0, 8'd0);
        wait_idle();

        // Maximum count: 16 EXEC cycles
        send(1'b0, OP_ADD, 1'b0, SH_RIGHT, 1'b1, 4'd15, 1'b0, 8'd0);
        wait_idle();

        // Reset sampled at the end of the 4th EXEC cycle of a long command
        send(1'b0, OP_ADD, 1'b0, SH_ROT, 1'b0, 4'd15, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        outstanding = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Randomised commands, fields jittering while held off, garbage during gaps
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'b0, 8'd0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    garbage();
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();

        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
